// File: rtl/puzzle_pkg.sv
// puzzle_pkg: shared encodings, constants and move helpers for the 15-puzzle board engine
package puzzle_pkg;
    typedef enum logic [1:0] {IDLE, MOVE, SHUFFLE} state_t;
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;
    localparam logic [63:0] SOLVED_BOARD = 64'h0FED_CBA9_8765_4321;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic is_legal(input logic [3:0] b, input logic [1:0] d);
        return d == DIR_UP ? b >= 4'd4 : d == DIR_DOWN ? b < 4'd12 :
               d == DIR_LEFT ? b[1:0] != 2'd0 : b[1:0] != 2'd3;
    endfunction
    function automatic logic [3:0] neighbour(input logic [3:0] b, input logic [1:0] d);
        return d == DIR_UP ? b - 4'd4 : d == DIR_DOWN ? b + 4'd4 :
               d == DIR_LEFT ? b - 4'd1 : b + 4'd1;
    endfunction
endpackage

// File: rtl/puzzle_board_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR used as the shuffle direction source
//   clk  : pixel-domain clock
//   rst  : asynchronous active-low reset, loads the non-zero seed
//   q    : current LFSR state
module lfsr16
    import puzzle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= LFSR_SEED;
        else      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
endmodule

// File: rtl/puzzle_board.sv
// puzzle_board: 15-puzzle board state with handshaked blank moves, LFSR shuffle and solved flag
//   clk, rst          : pixel clock, asynchronous active-low reset
//   move_valid/_dir   : blank-move request (0 up, 1 down, 2 left, 3 right)
//   move_ready        : request accepted this cycle when high with move_valid
//   shuffle_start     : begin a SHUFFLE_MOVES-long random shuffle (IDLE only)
//   board, pos[16]    : 16 nibbles row-major, 0 = blank; pos is the per-cell view for the VGA path
//   blank_pos, solved : blank index, board equals solved pattern
//   move_err          : one-cycle pulse after an illegal user move
//   move_count        : saturating legal user move count
//   busy              : shuffle in progress
module puzzle_board
    import puzzle_pkg::*;
#(
    parameter int SHUFFLE_MOVES = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    input  logic        shuffle_start,
    output logic [63:0] board,
    output logic [3:0]  pos [16],
    output logic [3:0]  blank_pos,
    output logic        solved,
    output logic        move_err,
    output logic [9:0]  move_count,
    output logic        busy
);
    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] remaining;
    logic [1:0]  dir;
    logic [1:0]  cur_dir;
    logic        legal;
    logic [3:0]  nbr;
    logic [63:0] swapped;

    lfsr16 u_lfsr (.clk(clk), .rst(rst), .q(lfsr));

    for (genvar k = 0; k < 16; k++) begin : g_pos
        assign pos[k] = board[4*k+3:4*k];
    end

    assign move_ready = (state == IDLE) && !shuffle_start;

    // Shuffle takes its direction straight from the LFSR; user moves use the latched request
    always_comb begin
        cur_dir = state == SHUFFLE ? lfsr[1:0] : dir;
        legal   = is_legal(blank_pos, cur_dir);
        nbr     = neighbour(blank_pos, cur_dir);
        swapped = board;
        swapped[4*blank_pos +: 4] = board[4*nbr +: 4];
        swapped[4*nbr +: 4]       = 4'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            board      <= SOLVED_BOARD;
            blank_pos  <= 4'd15;
            solved     <= 1'b1;
            move_err   <= 1'b0;
            move_count <= 10'd0;
            busy       <= 1'b0;
            remaining  <= 16'd0;
            dir        <= DIR_UP;
        end else begin
            move_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (shuffle_start) begin
                        state      <= SHUFFLE;
                        busy       <= 1'b1;
                        remaining  <= 16'(SHUFFLE_MOVES);
                        move_count <= 10'd0;
                    end else if (move_valid) begin
                        dir   <= move_dir;
                        state <= MOVE;
                    end
                end
                MOVE: begin
                    state <= IDLE;
                    if (legal) begin
                        board      <= swapped;
                        blank_pos  <= nbr;
                        solved     <= swapped == SOLVED_BOARD;
                        move_count <= move_count + 10'(move_count != 10'd1023);
                    end else begin
                        move_err <= 1'b1;
                    end
                end
                SHUFFLE: begin
                    // Illegal draws cost a cycle but do not consume a move
                    if (legal) begin
                        board     <= swapped;
                        blank_pos <= nbr;
                        solved    <= swapped == SOLVED_BOARD;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_puzzle_board.sv
// tb_puzzle_board: directed self-checking bench for puzzle_board
module tb_puzzle_board;
    localparam logic [63:0] SOLVED = 64'h0FEDCBA987654321;
    localparam logic [63:0] UP_ONCE = 64'hCFED0BA987654321;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        move_valid = 1'b0;
    logic [1:0]  move_dir = 2'd0;
    logic        shuffle_start = 1'b0;
    logic        move_ready, solved, move_err, busy;
    logic [63:0] board;
    logic [3:0]  pos [16];
    logic [3:0]  blank_pos;
    logic [9:0]  move_count;

    int errors = 0;
    int checks = 0;
    logic [15:0] mdl;
    logic [63:0] exp_board;
    logic [3:0]  exp_blank;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        mdl <= !rst ? 16'hACE1 : {mdl[14:0], mdl[15] ^ mdl[13] ^ mdl[12] ^ mdl[10]};

    puzzle_board #(.SHUFFLE_MOVES(8)) dut (
        .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir),
        .move_ready(move_ready), .shuffle_start(shuffle_start), .board(board),
        .pos(pos), .blank_pos(blank_pos), .solved(solved), .move_err(move_err),
        .move_count(move_count), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic step(input logic [3:0] b, input logic [1:0] d, output logic [3:0] nb);
        int r, c;
        r = int'(b) / 4;
        c = int'(b) % 4;
        case (d)
            2'd0: begin nb = b - 4'd4; return r > 0; end
            2'd1: begin nb = b + 4'd4; return r < 3; end
            2'd2: begin nb = b - 4'd1; return c > 0; end
            default: begin nb = b + 4'd1; return c < 3; end
        endcase
    endfunction

    task automatic do_move(input logic [1:0] d);
        move_valid = 1'b1;
        move_dir = d;
        @(posedge clk); #1;
        move_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Called one step after the edge that sampled shuffle_start; walks the bench's own LFSR
    task automatic run_shuffle();
        int left = 8;
        int cyc = 0;
        logic [3:0] nb;
        logic [15:0] seen = '0;
        move_valid = 1'b1;
        move_dir = 2'd0;
        while (left > 0 && cyc < 400) begin
            check("shuf_busy", busy, 1);
            check("shuf_ready", move_ready, 0);
            if (step(exp_blank, mdl[1:0], nb)) begin
                exp_board[4*exp_blank +: 4] = exp_board[4*nb +: 4];
                exp_board[4*nb +: 4] = 4'h0;
                exp_blank = nb;
                left--;
            end
            @(posedge clk); #1;
            cyc++;
            check("shuf_blank", blank_pos, exp_blank);
        end
        move_valid = 1'b0;
        check("shuf_swaps_left", left, 0);
        check("shuf_busy_end", busy, 0);
        check("shuf_board", board, exp_board);
        check("shuf_count", move_count, 0);
        check("shuf_solved", solved, exp_board == SOLVED);
        check("shuf_zero_cell", board[4*blank_pos +: 4], 0);
        for (int k = 0; k < 16; k++) seen[board[4*k +: 4]] = 1'b1;
        check("shuf_perm", seen, 16'hFFFF);
        check("shuf_ready_end", move_ready, 1);
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_board", board, SOLVED);
        check("rst_blank", blank_pos, 15);
        check("rst_solved", solved, 1);
        check("rst_count", move_count, 0);
        check("rst_ready", move_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", move_err, 0);
        check("rst_pos0", pos[0], 1);
        check("rst_pos14", pos[14], 15);

        move_valid = 1'b1;
        move_dir = 2'd0;
        @(posedge clk); #1;
        move_valid = 1'b0;
        check("mv_ready_low", move_ready, 0);
        check("mv_board_hold", board, SOLVED);
        @(posedge clk); #1;
        check("up_board", board, UP_ONCE);
        check("up_blank", blank_pos, 11);
        check("up_solved", solved, 0);
        check("up_count", move_count, 1);
        check("up_err", move_err, 0);
        check("up_ready", move_ready, 1);
        check("up_pos15", pos[15], 12);

        do_move(2'd1);
        check("down_board", board, SOLVED);
        check("down_solved", solved, 1);
        check("down_count", move_count, 2);

        apply_reset();
        do_move(2'd1);
        check("ill_down_err", move_err, 1);
        check("ill_down_board", board, SOLVED);
        check("ill_down_count", move_count, 0);
        @(posedge clk); #1;
        check("ill_down_err_pulse", move_err, 0);
        do_move(2'd3);
        check("ill_right_err", move_err, 1);
        check("ill_right_board", board, SOLVED);
        check("ill_right_count", move_count, 0);
        check("ill_right_blank", blank_pos, 15);

        do_move(2'd0);
        check("pre_shuf_count", move_count, 1);
        exp_board = UP_ONCE;
        exp_blank = 4'd11;
        shuffle_start = 1'b1;
        #1;
        check("start_ready", move_ready, 0);
        @(posedge clk); #1;
        shuffle_start = 1'b0;
        run_shuffle();

        shuffle_start = 1'b1;
        move_valid = 1'b1;
        move_dir = 2'd2;
        #1;
        check("both_ready", move_ready, 0);
        @(posedge clk); #1;
        shuffle_start = 1'b0;
        move_valid = 1'b0;
        run_shuffle();

        shuffle_start = 1'b1;
        @(posedge clk); #1;
        shuffle_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_board", board, SOLVED);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_blank", blank_pos, 15);
        check("mid_rst_solved", solved, 1);
        check("mid_rst_ready", move_ready, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_board", board, SOLVED);

        for (int i = 0; i < 1023; i++) do_move(i % 2 == 0 ? 2'd0 : 2'd1);
        check("sat_count_1023", move_count, 1023);
        check("sat_blank", blank_pos, 11);
        do_move(2'd1);
        check("sat_count_hold", move_count, 1023);
        check("sat_solved", solved, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/puzzle_board.md
# puzzle_board

Board-state engine for the 15-puzzle display path. Holds the 16 cell values that the VGA controller renders, accepts blank-tile move requests through a valid/ready handshake, performs LFSR-driven shuffles, and flags the solved condition. It sits between the button/debounce logic and the VGA controller, replacing the fixed tile assignments in the top level.

## Interface
- SHUFFLE_MOVES, 200: number of legal random swaps per shuffle (1..65535)
- clk  in  1  pixel-domain clock (PixelCLK at top)
- rst  in  1  asynchronous, active-low reset
- move_valid  in  1  move request present
- move_dir  in  2  direction the blank moves: 0 up, 1 down, 2 left, 3 right
- move_ready  out  1  block can accept a move this cycle
- shuffle_start  in  1  start a shuffle (sampled in IDLE only)
- board  out  64  cell k (row-major, 0 = top-left) at bits [4k+3:4k]; value 0 = blank
- blank_pos  out  4  index of the blank cell
- solved  out  1  board equals solved pattern
- move_err  out  1  one-cycle pulse: last accepted move was illegal
- move_count  out  10  legal user moves since reset/shuffle, saturates at 1023
- busy  out  1  shuffle in progress

## Operation
- Solved pattern: cell k = k+1 for k<15, cell 15 = 0, i.e. board = 64'h0FEDCBA987654321.
- Reset values: board = solved, blank_pos = 15, solved = 1, move_err = 0, move_count = 0, busy = 0, state IDLE, LFSR = 16'hACE1.
- States: IDLE, MOVE, SHUFFLE.
- IDLE: move_ready = ~shuffle_start (combinational). shuffle_start=1 -> SHUFFLE, load remaining = SHUFFLE_MOVES, clear move_count. Else move_valid & move_ready -> latch move_dir, go MOVE.
- MOVE (one cycle): legality from blank_pos b: up b>=4, down b<12, left b[1:0]!=0, right b[1:0]!=3. Neighbour n = b-4, b+4, b-1, b+1. Legal: swap cells b and n, blank_pos <= n, move_count += 1 (saturating). Illegal: board unchanged, move_err pulses. Return to IDLE.
- SHUFFLE: each cycle take LFSR[1:0] as direction; legal -> swap, remaining -= 1; illegal -> no change, remaining held. remaining reaches 0 -> IDLE. move_err never asserted, move_count not incremented. busy = 1, move_ready = 0 throughout.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle in all states (seed varies with user timing); never zero.
- solved is registered, updated on the same edge as board.
- Simultaneous shuffle_start and move_valid in IDLE: shuffle wins, no handshake occurs.
- move_valid outside IDLE: ignored, no handshake.
- Reset assertion at any time (incl. mid-shuffle/mid-move): all registers return to reset values immediately.

## Timing
- Move: handshake at edge t; MOVE during cycle t..t+1; board, blank_pos, solved, move_count, move_err update at edge t+1; move_ready high again after edge t+1. Throughput one move per 2 cycles.
- move_err high exactly one cycle after edge t+1.
- Shuffle: busy rises at the edge sampling shuffle_start; duration = SHUFFLE_MOVES + illegal-attempt cycles; busy falls on the edge performing the last legal swap.

## Structure
- puzzle_pkg: direction encodings, state enum, SOLVED_BOARD constant, LFSR_SEED, LFSR tap mask.
- Sub-module lfsr16 (clk, rst, q[15:0]), free-running.
- Top level slices board into posA..posP for the VGA controller.

## Test plan
- Reset -> board = 64'h0FEDCBA987654321, blank_pos = 15, solved = 1, move_count = 0, move_ready = 1.
- From reset, move up -> board cell 15 = 12, cell 11 = 0, blank_pos = 11, solved = 0, move_count = 1; then move down -> solved = 1, move_count = 2.
- From reset, move down and move right -> each yields single-cycle move_err, board unchanged, move_count = 0.
- SHUFFLE_MOVES = 8, pulse shuffle_start -> busy/move_ready=0 until exactly 8 swaps logged; board is a permutation of 0..15, blank_pos matches zero cell, move_count = 0.
- shuffle_start and move_valid same cycle in IDLE -> move_ready = 0, no MOVE, shuffle runs.
- Drop rst mid-shuffle -> solved board, busy = 0, state IDLE immediately; 1023+ legal moves -> move_count holds 1023.
